// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller.
// Size codes, FSM states, lane write-enable indices, helpers.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // bram_we bit driving each lane (lane0 holds the MSB)
  localparam int LANE0 = 3;
  localparam int LANE1 = 2;
  localparam int LANE2 = 1;
  localparam int LANE3 = 0;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    unique case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] align_off(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [1:0] o;
    unique case (size)
      SZ_BYTE: o = off;
      SZ_HALF: o = {off[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Memory-stage request/response bundle.
// master = pipeline MEM stage, slave = dmem_ctrl.
interface dmem_ctrl_if;

  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;

  modport master (
    output mem_read, mem_write, mem_size,
    output mem_unsigned, addr, wdata,
    input  stall, rdata, rdata_valid, misalign
  );

  modport slave (
    input  mem_read, mem_write, mem_size,
    input  mem_unsigned, addr, wdata,
    output stall, rdata, rdata_valid, misalign
  );

endinterface

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension.
// Lane0 is bits 31:24 of the BRAM word (big-endian).
module dmem_load_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        bs;
  logic        hs;

  // pick byte/half by offset, then extend
  always_comb begin
    b      = 8'h00;
    h      = 16'h0000;
    result = 32'h0;
    unique case (off)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];
    bs = b[7] & ~uns;
    hs = h[15] & ~uns;
    unique case (size)
      SZ_BYTE: result = {{24{bs}}, b};
      SZ_HALF: result = {{16{hs}}, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: load/store sequencing on 4 byte-lane BRAMs.
// Define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_ctrl_if.slave        mem,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata
);

  state_e      state_q;
  state_e      state_d;
  logic        mis;
  logic [1:0]  off;
  logic [3:0]  we_lanes;
  logic        accept;
  logic        stall;
  logic [1:0]  req_off;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        req_mis;
  logic [31:0] ld_data;
  logic [31:0] ld_final;
  logic [31:0] rdata_q;
  logic        valid_q;
  logic        unused_addr;

  assign unused_addr = ^mem.addr[31:ADDR_W+2];

  assign mis = misaligned(mem.mem_size, mem.addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign off = mem.addr[1:0];
`else
  assign off = align_off(mem.mem_size, mem.addr[1:0]);
`endif

  assign mem.misalign = (mem.mem_read | mem.mem_write) & mis;
  assign bram_addr    = mem.addr[ADDR_W+1:2];

  // store lane enables and lane-replicated data
  always_comb begin
    we_lanes   = 4'b0000;
    bram_wdata = mem.wdata;
    unique case (mem.mem_size)
      SZ_BYTE: begin
        we_lanes   = 4'b0000;
        unique case (off)
          2'd0:    we_lanes[LANE0] = 1'b1;
          2'd1:    we_lanes[LANE1] = 1'b1;
          2'd2:    we_lanes[LANE2] = 1'b1;
          default: we_lanes[LANE3] = 1'b1;
        endcase
        bram_wdata = {4{mem.wdata[7:0]}};
      end
      SZ_HALF: begin
        we_lanes   = off[1] ? 4'b0011 : 4'b1100;
        bram_wdata = {2{mem.wdata[15:0]}};
      end
      default: begin
        we_lanes   = 4'b1111;
        bram_wdata = mem.wdata;
      end
    endcase
  end

  // next state, stall and write strobe
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bram_we = 4'b0000;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem.mem_write) begin
`ifdef DMEM_MISALIGN_TRAP_EN
          bram_we = mis ? 4'b0000 : we_lanes;
`else
          bram_we = we_lanes;
`endif
        end else if (mem.mem_read) begin
          stall   = 1'b1;
          accept  = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        stall   = 1'b1;
        state_d = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // capture load shape when accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_off  <= 2'b00;
      req_size <= SZ_WORD;
      req_uns  <= 1'b0;
      req_mis  <= 1'b0;
    end else if (accept) begin
      req_off  <= off;
      req_size <= mem.mem_size;
      req_uns  <= mem.mem_unsigned;
      req_mis  <= mis;
    end
  end

  dmem_load_align u_align (
    .rdata  (bram_rdata),
    .off    (req_off),
    .size   (req_size),
    .uns    (req_uns),
    .result (ld_data)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign ld_final = req_mis ? 32'h0 : ld_data;
`else
  assign ld_final = ld_data;
  logic unused_mis;
  assign unused_mis = req_mis;
`endif

  // load result register and valid pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == RD_WAIT);
      if (state_q == RD_WAIT) rdata_q <= ld_final;
    end
  end

  assign mem.stall       = stall;
  assign mem.rdata       = rdata_q;
  assign mem.rdata_valid = valid_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: BRAM model, directed loads/stores,
// scoreboard queue checked by a separate rdata_valid monitor.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  bram_addr;
  logic [3:0]  bram_we;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata = 32'h0;
  logic [7:0]  lane [4][512];
  logic [31:0] sb [$];
  int          total = 0;
  int          bad = 0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.ADDR_W(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  always #5 clk = ~clk;

  // byte-lane BRAM model, registered read
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bram_we[3-k])
        lane[k][bram_addr] <= bram_wdata[31-8*k -: 8];
      bram_rdata[31-8*k -: 8] <= lane[k][bram_addr];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.rdata_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got %h want none", bus.rdata);
      end else begin
        chk("rdata", bus.rdata, sb.pop_front());
      end
    end
  end

  task automatic idle_req();
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_size     = 2'b10;
    bus.mem_unsigned = 1'b0;
    bus.addr         = 32'h0;
    bus.wdata        = 32'h0;
  endtask

  task automatic do_store(
    logic        rd,
    logic [1:0]  sz,
    logic [31:0] a,
    logic [31:0] d,
    logic [3:0]  we,
    logic [31:0] wd,
    logic        ms
  );
    bus.mem_read  = rd;
    bus.mem_write = 1'b1;
    bus.mem_size  = sz;
    bus.addr      = a;
    bus.wdata     = d;
    @(negedge clk);
    chk("st_we", 32'(bram_we), 32'(we));
    chk("st_addr", 32'(bram_addr), 32'(a[10:2]));
    if (we != 4'b0000) chk("st_wdata", bram_wdata, wd);
    chk("st_stall", 32'(bus.stall), 32'd0);
    chk("st_mis", 32'(bus.misalign), 32'(ms));
    @(posedge clk);
    #1 idle_req();
  endtask

  task automatic do_load(
    logic [1:0]  sz,
    logic        uns,
    logic [31:0] a,
    logic [31:0] exp,
    logic        ms
  );
    bus.mem_read     = 1'b1;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    bus.addr         = a;
    sb.push_back(exp);
    @(negedge clk);
    chk("ld_stall0", 32'(bus.stall), 32'd1);
    chk("ld_mis", 32'(bus.misalign), 32'(ms));
    @(posedge clk);
    @(negedge clk);
    chk("ld_stall1", 32'(bus.stall), 32'd1);
    chk("ld_val1", 32'(bus.rdata_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ld_stall2", 32'(bus.stall), 32'd0);
    chk("ld_val2", 32'(bus.rdata_valid), 32'd1);
    @(posedge clk);
    #1 idle_req();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_stall", 32'(bus.stall), 32'd0);
    chk("idle_we", 32'(bram_we), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e_mis_lw;
    logic [3:0]  e_mis_we;
    logic [31:0] e_after;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 512; w++)
        lane[k][w] = 8'h00;
`ifdef DMEM_MISALIGN_TRAP_EN
    e_mis_lw = 32'h0;
    e_mis_we = 4'b0000;
    e_after  = 32'h11223344;
`else
    e_mis_lw = 32'hDEADBEA5;
    e_mis_we = 4'b1100;
    e_after  = 32'h77773344;
`endif
    idle_req();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_valid", 32'(bus.rdata_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();

    do_store(1'b0, 2'b10, 32'h10, 32'hDEADBEEF,
             4'b1111, 32'hDEADBEEF, 1'b0);
    do_load(2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_store(1'b0, 2'b00, 32'h13, 32'h000000A5,
             4'b0001, 32'hA5A5A5A5, 1'b0);
    do_load(2'b00, 1'b0, 32'h13, 32'hFFFFFFA5, 1'b0);
    do_load(2'b00, 1'b1, 32'h13, 32'h000000A5, 1'b0);
    do_load(2'b00, 1'b0, 32'h10, 32'hFFFFFFDE, 1'b0);
    do_load(2'b01, 1'b1, 32'h10, 32'h0000DEAD, 1'b0);
    do_load(2'b01, 1'b0, 32'h12, 32'hFFFFBEA5, 1'b0);
    do_store(1'b0, 2'b01, 32'h22, 32'h00008001,
             4'b0011, 32'h80018001, 1'b0);
    do_load(2'b01, 1'b0, 32'h22, 32'hFFFF8001, 1'b0);
    do_load(2'b01, 1'b1, 32'h22, 32'h00008001, 1'b0);

    do_store(1'b1, 2'b10, 32'h30, 32'h11223344,
             4'b1111, 32'h11223344, 1'b0);
    idle_cycle();
    idle_cycle();
    do_load(2'b10, 1'b0, 32'h30, 32'h11223344, 1'b0);

    do_load(2'b10, 1'b0, 32'h12, e_mis_lw, 1'b1);
    do_store(1'b0, 2'b01, 32'h31, 32'h00007777,
             e_mis_we, 32'h77777777, 1'b1);
    do_load(2'b10, 1'b0, 32'h30, e_after, 1'b0);

    do_store(1'b0, 2'b10, 32'h810, 32'hCAFEF00D,
             4'b1111, 32'hCAFEF00D, 1'b0);
    do_load(2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0);

    bus.mem_read = 1'b1;
    bus.mem_size = 2'b10;
    bus.addr     = 32'h30;
    @(posedge clk);
    @(negedge clk);
    chk("rw_stall", 32'(bus.stall), 32'd1);
    rst_n        = 1'b0;
    bus.mem_read = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ab_stall", 32'(bus.stall), 32'd0);
    chk("ab_rdata", bus.rdata, 32'h0);
    chk("ab_valid", 32'(bus.rdata_valid), 32'd0);
    @(posedge clk);
    #1;
    idle_cycle();
    idle_cycle();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
